wide_alu_seq: RTL and testbench

WIDE_ALU_SEQ -- requirements
Module: wide_alu_seq

---
 rtl/wide_alu_seq_pkg.sv | 30 +++
 rtl/wide_alu_seq_alu.sv | 51 +++++
 rtl/wide_alu_seq.sv | 136 +++++++++++++
 tb/tb_wide_alu_seq.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/wide_alu_seq_pkg.sv
// Shared definitions for the byte-serial 16-bit ALU sequencer: opcodes,
// sequencer states and datapath widths.
package wide_alu_seq_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    kADD  = 3'd0,
    kSUB  = 3'd1,
    kSHL  = 3'd2,
    kSHR  = 3'd3,
    kXOR  = 3'd4,
    kAND  = 3'd5,
    kOR   = 3'd6,
    kPASS = 3'd7
  } op_mne;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FIRST  = 2'd1,
    S_SECOND = 2'd2,
    S_FIN    = 2'd3
  } seq_state_t;

  function automatic logic is_shift(input op_mne op);
    return (op == kSHL) || (op == kSHR);
  endfunction

endpackage

// File: rtl/wide_alu_seq_alu.sv
// Downstream 8-bit combinational ALU driven by wide_alu_seq through its ALU_*
// ports; instantiated by the parent, never by the sequencer itself.
module wide_alu_seq_alu
  import wide_alu_seq_pkg::*;
(
  input  logic [BYTE_W-1:0] a_i,
  input  logic [BYTE_W-1:0] b_i,
  input  op_mne             op_i,
  input  logic              c_in_i,
  input  logic              s_in_i,
  output logic [BYTE_W-1:0] out_o,
  output logic              c_out_o,
  output logic              s_out_o,
  output logic              zero_o
);

  logic [BYTE_W:0] sum;

  always_comb begin
    sum     = '0;
    out_o   = '0;
    c_out_o = 1'b0;
    s_out_o = 1'b0;
    unique case (op_i)
      kADD: begin
        sum     = {1'b0, a_i} + {1'b0, b_i} + {{BYTE_W{1'b0}}, c_in_i};
        out_o   = sum[BYTE_W-1:0];
        c_out_o = sum[BYTE_W];
      end
      kSUB: begin
        sum     = {1'b0, a_i} + {1'b0, ~b_i} + {{BYTE_W{1'b0}}, c_in_i};
        out_o   = sum[BYTE_W-1:0];
        c_out_o = sum[BYTE_W];
      end
      kSHL: begin
        out_o   = {a_i[BYTE_W-2:0], s_in_i};
        s_out_o = a_i[BYTE_W-1];
      end
      kSHR: begin
        out_o   = {s_in_i, a_i[BYTE_W-1:1]};
        s_out_o = a_i[0];
      end
      kXOR:    out_o = a_i ^ b_i;
      kAND:    out_o = a_i & b_i;
      kOR:     out_o = a_i | b_i;
      default: out_o = a_i;
    endcase
    zero_o = (out_o == '0);
  end

endmodule

// File: rtl/wide_alu_seq.sv
// 16-bit operation sequenced as two byte passes through an external 8-bit ALU;
// carry / shift-out is chained between the passes.
module wide_alu_seq
  import wide_alu_seq_pkg::*;
#(
  parameter logic SHIFT_FILL = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              start_i,
  input  op_mne             op_i,
  input  logic [WORD_W-1:0] a_i,
  input  logic [WORD_W-1:0] b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [WORD_W-1:0] result_o,
  output logic              carry_o,
  output logic              zero_o,
  output logic [BYTE_W-1:0] alu_a_o,
  output logic [BYTE_W-1:0] alu_b_o,
  output op_mne             alu_op_o,
  output logic              alu_c_in_o,
  output logic              alu_s_in_o,
  input  logic [BYTE_W-1:0] alu_out_i,
  input  logic              alu_c_out_i,
  input  logic              alu_s_out_i,
  input  logic              alu_zero_i
);

  seq_state_t        state_q, state_d;
  op_mne             op_q;
  logic [WORD_W-1:0] a_q, b_q, result_q, result_d;
  logic [BYTE_W-1:0] first_q, a_byte, b_byte;
  logic              chain_q, zero1_q, carry_q, carry_d, zero_q;
  logic              first_pass, hi_sel;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start_i) state_d = S_FIRST;
      S_FIRST:  state_d = S_SECOND;
      S_SECOND: state_d = S_FIN;
      default:  state_d = S_IDLE;
    endcase
  end

  // SHR walks from the high byte down so the shift-out chains into the low byte.
  assign first_pass = (state_q == S_FIRST);
  assign hi_sel     = (state_q == S_SECOND) ^ (op_q == kSHR);
  assign a_byte     = hi_sel ? a_q[WORD_W-1:BYTE_W] : a_q[BYTE_W-1:0];
  assign b_byte     = hi_sel ? b_q[WORD_W-1:BYTE_W] : b_q[BYTE_W-1:0];

  always_comb begin
    busy_o     = (state_q != S_IDLE);
    done_o     = (state_q == S_FIN);
    alu_a_o    = '0;
    alu_b_o    = '0;
    alu_op_o   = kPASS;
    alu_c_in_o = 1'b0;
    alu_s_in_o = 1'b0;
    if ((state_q == S_FIRST) || (state_q == S_SECOND)) begin
      alu_a_o = a_byte;
      unique case (op_q)
        kADD: begin
          alu_op_o   = kADD;
          alu_b_o    = b_byte;
          alu_c_in_o = first_pass ? 1'b0 : chain_q;
        end
        kSUB: begin
          alu_op_o   = kADD;
          alu_b_o    = ~b_byte;
          alu_c_in_o = first_pass ? 1'b1 : chain_q;
        end
        kSHL, kSHR: begin
          alu_op_o   = op_q;
          alu_b_o    = 8'd1;
          alu_s_in_o = first_pass ? SHIFT_FILL : chain_q;
        end
        default: begin
          alu_op_o = op_q;
          alu_b_o  = b_byte;
        end
      endcase
    end
  end

  always_comb begin
    result_d = (op_q == kSHR) ? {first_q, alu_out_i} : {alu_out_i, first_q};
    unique case (op_q)
      kADD, kSUB: carry_d = alu_c_out_i;
      kSHL:       carry_d = a_q[WORD_W-1];
      kSHR:       carry_d = a_q[0];
      default:    carry_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= kADD;
      a_q      <= '0;
      b_q      <= '0;
      first_q  <= '0;
      chain_q  <= 1'b0;
      zero1_q  <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      if ((state_q == S_IDLE) && start_i) begin
        op_q <= op_i;
        a_q  <= a_i;
        b_q  <= b_i;
      end
      if (state_q == S_FIRST) begin
        first_q <= alu_out_i;
        chain_q <= is_shift(op_q) ? alu_s_out_i : alu_c_out_i;
        zero1_q <= alu_zero_i;
      end
      if (state_q == S_SECOND) begin
        result_q <= result_d;
        carry_q  <= carry_d;
        zero_q   <= zero1_q & alu_zero_i;
      end
    end
  end

  assign result_o = result_q;
  assign carry_o  = carry_q;
  assign zero_o   = zero_q;

endmodule

// File: tb/tb_wide_alu_seq.sv
// Directed bench: wide_alu_seq wired to the 8-bit ALU, vector table plus
// hand-written sequences for START-while-busy and mid-operation reset.
module tb_wide_alu_seq;
  import wide_alu_seq_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  op_mne       op_i = kPASS;
  logic [15:0] a_i = '0, b_i = '0;
  logic        busy_o, done_o, carry_o, zero_o;
  logic [15:0] result_o;
  logic [7:0]  alu_a_o, alu_b_o, alu_out_i;
  op_mne       alu_op_o;
  logic        alu_c_in_o, alu_s_in_o, alu_c_out_i, alu_s_out_i, alu_zero_i;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  wide_alu_seq #(.SHIFT_FILL(1'b0)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .start_i(start_i), .op_i(op_i),
    .a_i(a_i), .b_i(b_i), .busy_o(busy_o), .done_o(done_o),
    .result_o(result_o), .carry_o(carry_o), .zero_o(zero_o),
    .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_op_o(alu_op_o),
    .alu_c_in_o(alu_c_in_o), .alu_s_in_o(alu_s_in_o),
    .alu_out_i(alu_out_i), .alu_c_out_i(alu_c_out_i),
    .alu_s_out_i(alu_s_out_i), .alu_zero_i(alu_zero_i)
  );

  wide_alu_seq_alu u_alu (
    .a_i(alu_a_o), .b_i(alu_b_o), .op_i(alu_op_o), .c_in_i(alu_c_in_o),
    .s_in_i(alu_s_in_o), .out_o(alu_out_i), .c_out_o(alu_c_out_i),
    .s_out_o(alu_s_out_i), .zero_o(alu_zero_i)
  );

  typedef struct {
    op_mne       op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        carry;
    logic        zero;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Issues one operation and checks DONE timing and the registered outputs.
  task automatic run_op(input vec_t v, input string tag);
    @(negedge clk_i);
    start_i = 1'b1; op_i = v.op; a_i = v.a; b_i = v.b;
    tick();
    start_i = 1'b0;
    check({tag, " busy n"}, {31'd0, busy_o}, 32'd1);
    check({tag, " done n"}, {31'd0, done_o}, 32'd0);
    tick();
    check({tag, " done n+1"}, {31'd0, done_o}, 32'd0);
    tick();
    check({tag, " done n+2"}, {31'd0, done_o}, 32'd1);
    check({tag, " result"}, {16'd0, result_o}, {16'd0, v.res});
    check({tag, " carry"}, {31'd0, carry_o}, {31'd0, v.carry});
    check({tag, " zero"}, {31'd0, zero_o}, {31'd0, v.zero});
    tick();
    check({tag, " done n+3"}, {31'd0, done_o}, 32'd0);
    check({tag, " busy n+3"}, {31'd0, busy_o}, 32'd0);
    check({tag, " result hold"}, {16'd0, result_o}, {16'd0, v.res});
  endtask

  initial begin
    vecs[0]  = '{kADD,  16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0};
    vecs[1]  = '{kADD,  16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1};
    vecs[2]  = '{kSUB,  16'h1000, 16'h0001, 16'h0FFF, 1'b1, 1'b0};
    vecs[3]  = '{kSUB,  16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0};
    vecs[4]  = '{kSHL,  16'h8080, 16'h0000, 16'h0100, 1'b1, 1'b0};
    vecs[5]  = '{kSHR,  16'h0101, 16'h0000, 16'h0080, 1'b1, 1'b0};
    vecs[6]  = '{kXOR,  16'h1234, 16'h00FF, 16'h12CB, 1'b0, 1'b0};
    vecs[7]  = '{kOR,   16'h1200, 16'h0034, 16'h1234, 1'b0, 1'b0};
    vecs[8]  = '{kPASS, 16'hABCD, 16'h5555, 16'hABCD, 1'b0, 1'b0};
    vecs[9]  = '{kAND,  16'h00FF, 16'hFF00, 16'h0000, 1'b0, 1'b1};
    vecs[10] = '{kADD,  16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0};

    #2;
    check("rst busy", {31'd0, busy_o}, 32'd0);
    check("rst done", {31'd0, done_o}, 32'd0);
    check("rst result", {16'd0, result_o}, 32'd0);
    check("rst alu_op", {29'd0, alu_op_o}, {29'd0, kPASS});
    check("rst alu_a", {24'd0, alu_a_o}, 32'd0);
    @(negedge clk_i);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 11; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // SUB first pass: low byte of ~B with carry-in 1
    @(negedge clk_i);
    start_i = 1'b1; op_i = kSUB; a_i = 16'h1000; b_i = 16'h0001;
    tick();
    start_i = 1'b0;
    check("sub first alu_b", {24'd0, alu_b_o}, 32'h0000_00FE);
    check("sub first alu_op", {29'd0, alu_op_o}, {29'd0, kADD});
    check("sub first c_in", {31'd0, alu_c_in_o}, 32'd1);
    tick();
    check("sub second alu_a", {24'd0, alu_a_o}, 32'h0000_0010);
    check("sub second c_in", {31'd0, alu_c_in_o}, 32'd0);
    tick();
    tick();
    check("idle alu_b", {24'd0, alu_b_o}, 32'd0);

    // START raised during SECOND must not launch a second operation
    @(negedge clk_i);
    start_i = 1'b1; op_i = kADD; a_i = 16'h0001; b_i = 16'h0001;
    tick();
    start_i = 1'b0;
    tick();
    @(negedge clk_i);
    start_i = 1'b1; op_i = kXOR; a_i = 16'hFFFF; b_i = 16'h0F0F;
    @(negedge clk_i);
    start_i = 1'b0;
    #1;
    check("ign done", {31'd0, done_o}, 32'd1);
    check("ign result", {16'd0, result_o}, 32'h0000_0002);
    tick();
    check("ign busy after", {31'd0, busy_o}, 32'd0);
    tick();
    check("ign busy later", {31'd0, busy_o}, 32'd0);
    check("ign done later", {31'd0, done_o}, 32'd0);
    check("ign result hold", {16'd0, result_o}, 32'h0000_0002);

    // reset pulsed while in FIRST aborts the operation
    @(negedge clk_i);
    start_i = 1'b1; op_i = kSUB; a_i = 16'h0000; b_i = 16'h0001;
    tick();
    start_i = 1'b0;
    @(negedge clk_i);
    rst_n = 1'b0;
    #1;
    check("abort busy", {31'd0, busy_o}, 32'd0);
    check("abort done", {31'd0, done_o}, 32'd0);
    check("abort result", {16'd0, result_o}, 32'd0);
    check("abort carry", {31'd0, carry_o}, 32'd0);
    check("abort zero", {31'd0, zero_o}, 32'd0);
    check("abort alu_a", {24'd0, alu_a_o}, 32'd0);
    check("abort alu_op", {29'd0, alu_op_o}, {29'd0, kPASS});
    for (int k = 0; k < 3; k++) begin
      tick();
      check("abort no done", {31'd0, done_o}, 32'd0);
    end
    @(negedge clk_i);
    rst_n = 1'b1;
    tick();
    check("abort idle done", {31'd0, done_o}, 32'd0);
    check("abort idle result", {16'd0, result_o}, 32'd0);
    run_op('{kAND, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0}, "post-rst and");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
